// File: rtl/fetch_unit_if.sv
// Fetch front-end bus: imem request/response, redirect and decode handshake.
// master = fetch unit side, slave = memory/decode/branch side.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    input  redirect_valid, redirect_pc,
    output out_valid, out_instr, out_pc,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    output redirect_valid, redirect_pc,
    input  out_valid, out_instr, out_pc,
    output out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Decoupled RV32I fetch: PC, 1-cycle imem requests, instr/PC FIFO to decode.
// Ports: clk, reset (async high), bus (fetch_unit_if.master), misalign_err, fetch_pc.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  fetch_unit_if.master    bus,
  output logic            misalign_err,
  output logic [XLEN-1:0] fetch_pc
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 32 + XLEN;

  logic [EW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] tag_q, tag_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;
  logic [31:0]     hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;

  logic            nonempty;
  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     occ;
  logic [EW-1:0]   head;

  assign nonempty = (count_q != '0);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    pop  = nonempty & bus.out_ready;
    // occupancy after this cycle: counts the response still in flight
    occ  = {1'b0, count_q} + (CW+1)'(inflight_q)
         - (CW+1)'(pop);
    issue = !reset & !bus.redirect_valid
          & (occ < (CW+1)'(DEPTH));
    push = inflight_q & !bus.redirect_valid;

    pc_d         = pc_q;
    tag_d        = tag_q;
    inflight_d   = issue;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    mis_d        = bus.redirect_valid
                 & (bus.redirect_pc[1:0] != 2'b00);

    if (issue) begin
      pc_d  = pc_q + XLEN'(4);
      tag_d = pc_q;
    end

    if (nonempty) begin
      hold_instr_d = head[EW-1:XLEN];
      hold_pc_d    = head[XLEN-1:0];
    end

    if (bus.redirect_valid) begin
      pc_d     = {bus.redirect_pc[XLEN-1:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      tag_q        <= '0;
      inflight_q   <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      mis_q        <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      tag_q        <= tag_d;
      inflight_q   <= inflight_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      mis_q        <= mis_d;
    end
  end

  // storage needs no reset: count gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.imem_rdata, tag_q};
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_q;
  assign bus.out_valid = nonempty;
  assign bus.out_instr = nonempty ? head[EW-1:XLEN] : hold_instr_q;
  assign bus.out_pc    = nonempty ? head[XLEN-1:0] : hold_pc_q;
  assign misalign_err  = mis_q;
  assign fetch_pc      = pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus reset/wrap sequences.
// Two instances: RESET_PC=0 (main) and RESET_PC=0xFFFFFFF8 (wrap).
module tb_fetch_unit;
  logic        clk;
  logic        reset;
  logic        mis0, mis1;
  logic [31:0] fpc0, fpc1;
  int          checks;
  int          errors;

  fetch_unit_if #(.XLEN(32)) if0 ();
  fetch_unit_if #(.XLEN(32)) if1 ();

  fetch_unit #(
    .XLEN(32), .RESET_PC(32'h0), .DEPTH(2)
  ) u0 (
    .clk(clk), .reset(reset), .bus(if0),
    .misalign_err(mis0), .fetch_pc(fpc0)
  );

  fetch_unit #(
    .XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)
  ) u1 (
    .clk(clk), .reset(reset), .bus(if1),
    .misalign_err(mis1), .fetch_pc(fpc1)
  );

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // 1-cycle memory: instruction derived from address
  always @(posedge clk) begin
    if0.imem_rdata <= f(if0.imem_addr);
    if1.imem_rdata <= f(if1.imem_addr);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic        ereq;
    logic [31:0] efpc;
    logic        emis;
  } vec_t;

  vec_t tbl[31];
  logic [31:0] wrap_pc[4];

  function automatic vec_t v(
    input logic rdy, input logic rv, input logic [31:0] rpc,
    input logic ev, input logic [31:0] epc,
    input logic ereq, input logic [31:0] efpc, input logic emis);
    vec_t r;
    r.rdy = rdy; r.rv = rv; r.rpc = rpc;
    r.ev = ev; r.epc = epc; r.ereq = ereq;
    r.efpc = efpc; r.emis = emis;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rv,
                       input logic [31:0] rpc);
    if0.out_ready = rdy; if0.redirect_valid = rv;
    if0.redirect_pc = rpc;
    if1.out_ready = rdy; if1.redirect_valid = rv;
    if1.redirect_pc = rpc;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    // stream, then stall, redirect, misaligned and back-to-back
    tbl[0]  = v(1, 0, 0, 0, 32'h0,   1, 32'h0,   0);
    tbl[1]  = v(1, 0, 0, 0, 32'h0,   1, 32'h4,   0);
    tbl[2]  = v(1, 0, 0, 1, 32'h0,   1, 32'h8,   0);
    tbl[3]  = v(1, 0, 0, 1, 32'h4,   1, 32'hC,   0);
    tbl[4]  = v(1, 0, 0, 1, 32'h8,   1, 32'h10,  0);
    tbl[5]  = v(1, 0, 0, 1, 32'hC,   1, 32'h14,  0);
    tbl[6]  = v(0, 0, 0, 1, 32'h10,  0, 32'h18,  0);
    tbl[7]  = v(0, 0, 0, 1, 32'h10,  0, 32'h18,  0);
    tbl[8]  = v(0, 0, 0, 1, 32'h10,  0, 32'h18,  0);
    tbl[9]  = v(0, 0, 0, 1, 32'h10,  0, 32'h18,  0);
    tbl[10] = v(0, 0, 0, 1, 32'h10,  0, 32'h18,  0);
    tbl[11] = v(0, 0, 0, 1, 32'h10,  0, 32'h18,  0);
    tbl[12] = v(1, 0, 0, 1, 32'h10,  1, 32'h18,  0);
    tbl[13] = v(1, 0, 0, 1, 32'h14,  1, 32'h1C,  0);
    tbl[14] = v(1, 0, 0, 1, 32'h18,  1, 32'h20,  0);
    tbl[15] = v(1, 0, 0, 1, 32'h1C,  1, 32'h24,  0);
    tbl[16] = v(0, 0, 0, 1, 32'h20,  0, 32'h28,  0);
    tbl[17] = v(0, 1, 32'h100,
                1, 32'h20,  0, 32'h28,  0);
    tbl[18] = v(1, 0, 0, 0, 32'h20,  1, 32'h100, 0);
    tbl[19] = v(1, 0, 0, 0, 32'h20,  1, 32'h104, 0);
    tbl[20] = v(1, 0, 0, 1, 32'h100, 1, 32'h108, 0);
    tbl[21] = v(1, 0, 0, 1, 32'h104, 1, 32'h10C, 0);
    tbl[22] = v(1, 1, 32'h102,
                1, 32'h108, 0, 32'h110, 0);
    tbl[23] = v(1, 0, 0, 0, 32'h108, 1, 32'h100, 1);
    tbl[24] = v(1, 0, 0, 0, 32'h108, 1, 32'h104, 0);
    tbl[25] = v(1, 0, 0, 1, 32'h100, 1, 32'h108, 0);
    tbl[26] = v(1, 1, 32'h203,
                1, 32'h104, 0, 32'h10C, 0);
    tbl[27] = v(1, 1, 32'h301,
                0, 32'h104, 0, 32'h200, 1);
    tbl[28] = v(1, 0, 0, 0, 32'h104, 1, 32'h300, 1);
    tbl[29] = v(1, 0, 0, 0, 32'h104, 1, 32'h304, 0);
    tbl[30] = v(1, 0, 0, 1, 32'h300, 1, 32'h308, 0);

    wrap_pc[0] = 32'hFFFF_FFF8;
    wrap_pc[1] = 32'hFFFF_FFFC;
    wrap_pc[2] = 32'h0000_0000;
    wrap_pc[3] = 32'h0000_0004;

    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst valid", 32'(if0.out_valid), 32'd0);
    chk("rst req", 32'(if0.imem_req), 32'd0);
    chk("rst pc", if0.out_pc, 32'h0);
    chk("rst instr", if0.out_instr, 32'h0);
    chk("rst mis", 32'(mis0), 32'd0);
    chk("rst fpc0", fpc0, 32'h0);
    chk("rst fpc1", fpc1, 32'hFFFF_FFF8);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 31; i++) begin
      if (i > 0) @(negedge clk);
      drive(tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
      #1;
      chk($sformatf("c%0d valid", i),
          32'(if0.out_valid), 32'(tbl[i].ev));
      chk($sformatf("c%0d out_pc", i),
          if0.out_pc, tbl[i].epc);
      if (tbl[i].ev)
        chk($sformatf("c%0d instr", i),
            if0.out_instr, f(tbl[i].epc));
      chk($sformatf("c%0d req", i),
          32'(if0.imem_req), 32'(tbl[i].ereq));
      chk($sformatf("c%0d fetch_pc", i),
          fpc0, tbl[i].efpc);
      chk($sformatf("c%0d addr", i),
          if0.imem_addr, tbl[i].efpc);
      chk($sformatf("c%0d mis", i),
          32'(mis0), 32'(tbl[i].emis));
      if (i >= 2 && i <= 5) begin
        chk($sformatf("wrap c%0d pc", i),
            if1.out_pc, wrap_pc[i-2]);
        chk($sformatf("wrap c%0d valid", i),
            32'(if1.out_valid), 32'd1);
        chk($sformatf("wrap c%0d instr", i),
            if1.out_instr, f(wrap_pc[i-2]));
      end
    end

    // asynchronous reset between edges while streaming
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async valid", 32'(if0.out_valid), 32'd0);
    chk("async fpc", fpc0, 32'h0);
    chk("async req", 32'(if0.imem_req), 32'd0);
    chk("async pc", if0.out_pc, 32'h0);
    chk("async fpc1", fpc1, 32'hFFFF_FFF8);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'h0);
    #1;
    chk("rs0 valid", 32'(if0.out_valid), 32'd0);
    chk("rs0 req", 32'(if0.imem_req), 32'd1);
    chk("rs0 fpc", fpc0, 32'h0);
    @(negedge clk);
    #1;
    chk("rs1 valid", 32'(if0.out_valid), 32'd0);
    chk("rs1 fpc", fpc0, 32'h4);
    @(negedge clk);
    #1;
    chk("rs2 valid", 32'(if0.out_valid), 32'd1);
    chk("rs2 pc", if0.out_pc, 32'h0);
    chk("rs2 instr", if0.out_instr, f(32'h0));
    @(negedge clk);
    #1;
    chk("rs3 valid", 32'(if0.out_valid), 32'd1);
    chk("rs3 pc", if0.out_pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end for the RV32I core. It replaces the bare PC register plus direct instruction-memory read with a decoupled fetch stage. The block holds the fetch PC, issues requests to a fixed-latency instruction memory and buffers returned instructions with their PCs in a small FIFO. It hands instructions to decode over a valid/ready handshake and supports redirects (branch/jump) with flush of stale fetches.

Parameters:
XLEN, 32, width of PC and address buses
RESET_PC, 0, fetch PC loaded on reset
DEPTH, 2, instruction buffer entries (legal: 2..16, power of two)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request this cycle
imem_addr  output  XLEN  fetch address, equals fetch_pc
imem_rdata  input  32  instruction word, valid exactly 1 cycle after imem_req
redirect_valid  input  1  redirect fetch to redirect_pc
redirect_pc  input  XLEN  redirect target
out_valid  output  1  buffered instruction available
out_ready  input  1  decode accepts instruction
out_instr  output  32  instruction at FIFO head
out_pc  output  XLEN  PC of out_instr
misalign_err  output  1  one-cycle pulse: redirect target not word-aligned
fetch_pc  output  XLEN  current fetch PC (debug/monitor)

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC; FIFO empty; in-flight flag 0; out_valid=0; out_instr=0; out_pc=0; misalign_err=0. imem_req=0 while reset is high.
- pop = out_valid & out_ready. Memory accepts every request; latency is fixed at 1 cycle.
- imem_req = !reset & !redirect_valid & (count + inflight - pop < DEPTH). This has a combinational path from out_ready; it is required so the block sustains 1 instr/cycle.
- On issue: inflight<=1 and tag<=addr; fetch_pc<=fetch_pc+4, modulo 2^XLEN (wraps to 0).
- Cycle after issue: if not discarded, {imem_rdata, tag} is written to the FIFO tail at the clock edge.
- Latency: request in cycle N gives out_valid in cycle N+2. There is no bypass around the FIFO.
- The FIFO is a circular buffer with wrapping pointers. Push and pop in the same cycle are both performed and count is unchanged.
- Full: no request is issued, so no overflow is possible. Empty: out_valid=0, and out_instr/out_pc hold their last values.
- Redirect (redirect_valid=1 at edge):
  - fetch_pc<=redirect_pc & ~3, FIFO flushed (count=0), and any in-flight response is discarded (the next cycle's imem_rdata is not written).
  - Redirect has priority over push.
  - A pop in the redirect cycle completes normally: that instruction counts as delivered. out_valid is not masked combinationally.
  - Fetching resumes the next cycle. The first post-redirect instruction reaches out_valid at redirect cycle+3.
- Misaligned redirect (redirect_pc[1:0]!=0): misalign_err=1 for exactly the next cycle. The fetch uses the aligned address.
- Back-to-back redirects: the last one wins. Each misaligned redirect produces its own pulse.
- Reset asserted mid-stream: all state clears immediately. No stale push occurs after reset deasserts.

Test Plan:
1. RESET_PC=0, memory returns {addr}; deassert reset with out_ready=1 -> out_pc 0x0 two cycles after the first imem_req, then 0x4, 0x8, 0xC on consecutive cycles; out_instr matches each PC.
2. Hold out_ready=0 for 6 cycles -> exactly DEPTH entries buffered, imem_req=0 once full, fetch_pc frozen; raise out_ready -> consecutive PCs with none lost or duplicated.
3. Fill the FIFO, then pulse redirect_valid with redirect_pc=0x100 -> no stale PCs delivered; next out_pc=0x100 at redirect+3, then 0x104.
4. Redirect with redirect_pc=0x102 -> misalign_err high for one cycle; fetch resumes at 0x100.
5. RESET_PC=0xFFFFFFF8 -> out_pc sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004.
6. Assert reset asynchronously between edges mid-stream -> out_valid=0, fetch_pc=RESET_PC immediately; after release, the stream restarts from RESET_PC.
